// File: rtl/ofm_port_arbiter.sv
// ofm_port_arbiter: shares one single-port OFM RAM between the FU write-out
// path and the next-layer IFM read path. One RAM command per cycle, registered
// toward the RAM; read data returns RD_LATENCY cycles after the command.
// Optional macro OFM_ARB_STARVE_GUARD_EN adds a read starvation guard
// (wait counter + FORCE_RD state); without it writes always win.
module ofm_port_arbiter #(
   parameter int ADDR_WIDTH  = 22,
   parameter int INOUT_WIDTH = 256,
   parameter int RD_LATENCY  = 1,
   parameter int MAX_WAIT    = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   hold,
   input  logic                   wr_valid,
   output logic                   wr_ready,
   input  logic [ADDR_WIDTH-1:0]  wr_addr,
   input  logic [INOUT_WIDTH-1:0] wr_data,
   input  logic [4:0]             wr_size,
   input  logic                   rd_valid,
   output logic                   rd_ready,
   input  logic [ADDR_WIDTH-1:0]  rd_addr,
   output logic                   rd_data_valid,
   output logic [INOUT_WIDTH-1:0] rd_data,
   output logic                   ram_en,
   output logic                   ram_we,
   output logic [ADDR_WIDTH-1:0]  ram_addr,
   output logic [INOUT_WIDTH-1:0] ram_wdata,
   output logic [4:0]             ram_wsize,
   input  logic [INOUT_WIDTH-1:0] ram_rdata,
   output logic                   idle
);

   // In-flight reads top out at RD_LATENCY + 1 (pipe full plus one accepted).
   localparam int CNT_W = $clog2(RD_LATENCY + 2);

   logic                  grant_ok;
   logic                  force_rd;
   logic                  wr_acc;
   logic                  rd_acc;
   logic [RD_LATENCY-1:0] vld_pipe;
   logic [CNT_W-1:0]      inflight;

`ifdef OFM_ARB_STARVE_GUARD_EN
   typedef enum logic [1:0] {
      GRANT_FREE = 2'd0,
      HOLD       = 2'd1,
      FORCE_RD   = 2'd2
   } arb_state_t;

   localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

   arb_state_t state, state_nxt;
   logic [7:0] wait_cnt, wait_nxt;

   assign force_rd = (state == FORCE_RD);
`else
   typedef enum logic {
      GRANT_FREE = 1'b0,
      HOLD       = 1'b1
   } arb_state_t;

   arb_state_t state, state_nxt;

   assign force_rd = 1'b0;
`endif

   // Handshake: nothing is granted under hold or reset; writes win unless a
   // forced read is pending.
   always_comb begin
      grant_ok = !rst && !hold;
      rd_ready = grant_ok && rd_valid && (!wr_valid || force_rd);
      wr_ready = grant_ok && wr_valid && !(force_rd && rd_valid);
      wr_acc   = wr_valid && wr_ready;
      rd_acc   = rd_valid && rd_ready;
   end

`ifdef OFM_ARB_STARVE_GUARD_EN
   // Next-state and starvation counter; counter saturates at MAX_WAIT, the
   // cycle it gets there the arbiter moves to FORCE_RD.
   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      if (!rd_valid || rd_acc)
         wait_nxt = 8'd0;
      else if (!hold && wait_cnt != MAX_W)
         wait_nxt = wait_cnt + 8'd1;
      case (state)
         GRANT_FREE: begin
            if (hold)
               state_nxt = HOLD;
            else if (wait_nxt == MAX_W)
               state_nxt = FORCE_RD;
         end
         HOLD: begin
            if (!hold)
               state_nxt = (wait_nxt == MAX_W) ? FORCE_RD : GRANT_FREE;
         end
         FORCE_RD: begin
            // Under hold the force stays armed; otherwise the read went out
            // (or was withdrawn) this cycle.
            if (!hold)
               state_nxt = GRANT_FREE;
         end
         default: state_nxt = GRANT_FREE;
      endcase
   end

   // State and wait counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= GRANT_FREE;
         wait_cnt <= 8'd0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
      end
   end
`else
   // Next-state: only tracks hold; grants are pure write priority.
   always_comb begin
      state_nxt = state;
      case (state)
         GRANT_FREE: if (hold)  state_nxt = HOLD;
         HOLD:       if (!hold) state_nxt = GRANT_FREE;
         default:    state_nxt = GRANT_FREE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= GRANT_FREE;
      else
         state <= state_nxt;
   end
`endif

   // Registered RAM command; address/data/size hold when nothing is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         ram_wsize <= '0;
      end else if (wr_acc) begin
         ram_en    <= 1'b1;
         ram_we    <= 1'b1;
         ram_addr  <= wr_addr;
         ram_wdata <= wr_data;
         ram_wsize <= wr_size;
      end else if (rd_acc) begin
         ram_en    <= 1'b1;
         ram_we    <= 1'b0;
         ram_addr  <= rd_addr;
      end else begin
         ram_en    <= 1'b0;
      end
   end

   // Read-return valid shift register, one stage per cycle of RAM latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[0] <= ram_en && !ram_we;
         for (int i = 1; i < RD_LATENCY; i++)
            vld_pipe[i] <= vld_pipe[i-1];
      end
   end

   assign rd_data_valid = vld_pipe[RD_LATENCY-1];
   assign rd_data       = ram_rdata;

   // In-flight read count: +1 on acceptance, -1 on return.
   always_ff @(posedge clk) begin
      if (rst)
         inflight <= '0;
      else if (rd_acc && !rd_data_valid)
         inflight <= inflight + 1'b1;
      else if (!rd_acc && rd_data_valid)
         inflight <= inflight - 1'b1;
   end

   assign idle = (inflight == '0) && !ram_en;

endmodule

// File: tb/tb_ofm_port_arbiter.sv
// Directed bench for ofm_port_arbiter (RD_LATENCY = 2, MAX_WAIT = 8) with a
// small behavioural RAM model providing ram_rdata.
module tb_ofm_port_arbiter;
   localparam int AW  = 22;
   localparam int DW  = 256;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          rst, hold, wr_valid, rd_valid;
   logic          wr_ready, rd_ready, rd_data_valid, ram_en, ram_we, idle;
   logic [AW-1:0] wr_addr, rd_addr, ram_addr;
   logic [DW-1:0] wr_data, rd_data, ram_wdata, ram_rdata;
   logic [4:0]    wr_size, ram_wsize;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ofm_port_arbiter #(.ADDR_WIDTH(AW), .INOUT_WIDTH(DW), .RD_LATENCY(LAT), .MAX_WAIT(8)) dut (
      .clk(clk), .rst(rst), .hold(hold),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_size(wr_size),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
      .rd_data_valid(rd_data_valid), .rd_data(rd_data),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_wsize(ram_wsize), .ram_rdata(ram_rdata), .idle(idle)
   );

   // Written data pattern and the pattern an unwritten word reads back as.
   function automatic logic [DW-1:0] mkd(input logic [AW-1:0] a);
      return {8{32'hA5A5_0000 ^ 32'(a)}};
   endfunction
   function automatic logic [DW-1:0] unw(input logic [AW-1:0] a);
      return {8{32'hDEAD_0000 | 32'(a)}};
   endfunction

   // RAM model: 256-word store, read data out LAT cycles after the command.
   logic [DW-1:0] mem [256];
   logic          wrt [256];
   logic [DW-1:0] rpipe [LAT];
   initial for (int i = 0; i < 256; i++) wrt[i] = 1'b0;
   always @(posedge clk) begin
      if (ram_en && ram_we) begin
         mem[ram_addr[7:0]] <= ram_wdata;
         wrt[ram_addr[7:0]] <= 1'b1;
      end
      if (ram_en && !ram_we)
         rpipe[0] <= wrt[ram_addr[7:0]] ? mem[ram_addr[7:0]] : unw(ram_addr);
      else
         rpipe[0] <= '0;
      for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
   end
   assign ram_rdata = rpipe[LAT-1];

   assign wr_data = mkd(wr_addr);
   assign wr_size = wr_addr[4:0];

   task automatic chkb(input string nm, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%b want=%b", nm, act, exp);
      end
   endtask

   task automatic chkv(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   // One cycle: inputs change 2 ns after the edge, outputs sampled at +5.
   task automatic cyc(input logic r, input logic h, input logic wv, input logic rv,
                      input logic [AW-1:0] wa, input logic [AW-1:0] ra);
      @(posedge clk);
      #2;
      rst = r; hold = h; wr_valid = wv; rd_valid = rv; wr_addr = wa; rd_addr = ra;
      #3;
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while (!idle && n < 12) begin
         cyc(0, 0, 0, 0, '0, '0);
         n++;
      end
      chkb({nm, "_drain_idle"}, idle, 1'b1);
   endtask

   typedef struct {
      logic h, wv, rv;
      logic [AW-1:0] wa, ra;
      logic e_wr, e_rd, e_en, e_we;
      logic [AW-1:0] e_addr;
      logic e_dv;
      logic [DW-1:0] e_dat;
      logic e_idle;
   } vec_t;

   function automatic vec_t mk(input logic h, wv, rv, input logic [AW-1:0] wa, ra,
                               input logic e_wr, e_rd, e_en, e_we, input logic [AW-1:0] e_addr,
                               input logic e_dv, input logic [DW-1:0] e_dat, input logic e_idle);
      vec_t v;
      v.h = h; v.wv = wv; v.rv = rv; v.wa = wa; v.ra = ra;
      v.e_wr = e_wr; v.e_rd = e_rd; v.e_en = e_en; v.e_we = e_we; v.e_addr = e_addr;
      v.e_dv = e_dv; v.e_dat = e_dat; v.e_idle = e_idle;
      return v;
   endfunction

   vec_t vt [16];

   initial begin
      logic prev_rd;
      logic exp_rd;
      int   dv_seen;

      // Mixed W/R traffic, single read of 0x100, hold blocking grants.
      //          h  wv rv wa     ra      wr rd en we addr   dv data        idle
      vt[0]  = mk(0, 0, 0, 0,     0,      0, 0, 0, 0, 0,     0, '0,         1);
      vt[1]  = mk(0, 1, 0, 'h10,  0,      1, 0, 0, 0, 0,     0, '0,         1);
      vt[2]  = mk(0, 0, 1, 0,     'h10,   0, 1, 1, 1, 'h10,  0, '0,         0);
      vt[3]  = mk(0, 1, 0, 'h21,  0,      1, 0, 1, 0, 'h10,  0, '0,         0);
      vt[4]  = mk(0, 0, 1, 0,     'h21,   0, 1, 1, 1, 'h21,  0, '0,         0);
      vt[5]  = mk(0, 0, 0, 0,     0,      0, 0, 1, 0, 'h21,  1, mkd('h10),  0);
      vt[6]  = mk(0, 0, 0, 0,     0,      0, 0, 0, 0, 'h21,  0, '0,         0);
      vt[7]  = mk(0, 0, 0, 0,     0,      0, 0, 0, 0, 'h21,  1, mkd('h21),  0);
      vt[8]  = mk(0, 0, 0, 0,     0,      0, 0, 0, 0, 'h21,  0, '0,         1);
      vt[9]  = mk(1, 1, 0, 'h30,  0,      0, 0, 0, 0, 'h21,  0, '0,         1);
      vt[10] = mk(1, 1, 1, 'h30,  'h40,   0, 0, 0, 0, 'h21,  0, '0,         1);
      vt[11] = mk(0, 0, 1, 0,     'h100,  0, 1, 0, 0, 'h21,  0, '0,         1);
      vt[12] = mk(0, 0, 0, 0,     0,      0, 0, 1, 0, 'h100, 0, '0,         0);
      vt[13] = mk(0, 0, 0, 0,     0,      0, 0, 0, 0, 'h100, 0, '0,         0);
      vt[14] = mk(0, 0, 0, 0,     0,      0, 0, 0, 0, 'h100, 1, unw('h100), 0);
      vt[15] = mk(0, 0, 0, 0,     0,      0, 0, 0, 0, 'h100, 0, '0,         1);

      // Reset with requests pending: no grant while rst is high.
      rst = 1'b1; hold = 1'b0; wr_valid = 1'b1; rd_valid = 1'b1; wr_addr = '0; rd_addr = '0;
      repeat (3) @(posedge clk);
      #5;
      chkb("rst_wr_ready", wr_ready, 1'b0);
      chkb("rst_rd_ready", rd_ready, 1'b0);
      chkb("rst_ram_en", ram_en, 1'b0);
      chkb("rst_ram_we", ram_we, 1'b0);
      chkv("rst_ram_addr", DW'(ram_addr), '0);
      chkv("rst_ram_wdata", ram_wdata, '0);
      chkv("rst_ram_wsize", DW'(ram_wsize), '0);
      chkb("rst_rd_dv", rd_data_valid, 1'b0);
      chkb("rst_idle", idle, 1'b1);

      for (int i = 0; i < 16; i++) begin
         cyc(0, vt[i].h, vt[i].wv, vt[i].rv, vt[i].wa, vt[i].ra);
         chkb($sformatf("v%0d_wr_ready", i), wr_ready, vt[i].e_wr);
         chkb($sformatf("v%0d_rd_ready", i), rd_ready, vt[i].e_rd);
         chkb($sformatf("v%0d_ram_en", i), ram_en, vt[i].e_en);
         chkb($sformatf("v%0d_ram_we", i), ram_we, vt[i].e_we);
         chkv($sformatf("v%0d_ram_addr", i), DW'(ram_addr), DW'(vt[i].e_addr));
         chkb($sformatf("v%0d_rd_dv", i), rd_data_valid, vt[i].e_dv);
         chkb($sformatf("v%0d_idle", i), idle, vt[i].e_idle);
         if (vt[i].e_dv)
            chkv($sformatf("v%0d_rd_data", i), rd_data, vt[i].e_dat);
         if (vt[i].e_en && vt[i].e_we) begin
            chkv($sformatf("v%0d_ram_wdata", i), ram_wdata, mkd(vt[i].e_addr));
            chkv($sformatf("v%0d_ram_wsize", i), DW'(ram_wsize), DW'(vt[i].e_addr[4:0]));
         end
      end

`ifdef OFM_ARB_STARVE_GUARD_EN
      // Both valid continuously: read forced through on every 9th cycle.
      prev_rd = 1'b0;
      for (int k = 0; k < 18; k++) begin
         cyc(0, 0, 1, 1, AW'('h30 + k), 'h40);
         exp_rd = (k == 8) || (k == 17);
         chkb($sformatf("starve%0d_rd_ready", k), rd_ready, exp_rd);
         chkb($sformatf("starve%0d_wr_ready", k), wr_ready, !exp_rd);
         if (k > 0) chkb($sformatf("starve%0d_ram_we", k), ram_we, !prev_rd);
         prev_rd = exp_rd;
      end
      cyc(0, 0, 0, 0, '0, '0);
      chkb("starve_last_ram_we", ram_we, 1'b0);
      drain("starve");
`else
      // Both valid continuously: write always wins.
      for (int k = 0; k < 5; k++) begin
         cyc(0, 0, 1, 1, AW'('h30 + k), 'h40);
         chkb($sformatf("prio%0d_wr_ready", k), wr_ready, 1'b1);
         chkb($sformatf("prio%0d_rd_ready", k), rd_ready, 1'b0);
         if (k > 0) chkb($sformatf("prio%0d_ram_we", k), ram_we, 1'b1);
      end
      cyc(0, 0, 0, 0, '0, '0);
      chkb("prio5_ram_en", ram_en, 1'b1);
      chkb("prio5_ram_we", ram_we, 1'b1);
      chkv("prio5_ram_addr", DW'(ram_addr), DW'('h34));
      drain("prio");
`endif

      // Three reads in flight, then hold: returns still complete.
      for (int k = 0; k < 3; k++) begin
         cyc(0, 0, 0, 1, '0, AW'('h50 + k));
         chkb($sformatf("hold_issue%0d_rd_ready", k), rd_ready, 1'b1);
      end
      dv_seen = 0;
      for (int k = 3; k < 9; k++) begin
         cyc(0, 1, 1, 1, 'h70, 'h71);
         chkb($sformatf("hold%0d_wr_ready", k), wr_ready, 1'b0);
         chkb($sformatf("hold%0d_rd_ready", k), rd_ready, 1'b0);
         chkb($sformatf("hold%0d_rd_dv", k), rd_data_valid, (k >= 3) && (k <= 5));
         chkb($sformatf("hold%0d_idle", k), idle, k >= 6);
         if (rd_data_valid) begin
            chkv($sformatf("hold%0d_rd_data", k), rd_data, unw(AW'('h50 + k - 3)));
            dv_seen++;
         end
      end
      total++;
      if (dv_seen != 3) begin
         bad++;
         $display("FAIL hold_return_count got=%0d want=3", dv_seen);
      end
      cyc(0, 0, 0, 0, '0, '0);
      drain("hold");

      // Reset in the middle of a read burst discards everything pending.
      cyc(0, 0, 0, 1, '0, 'h60);
      chkb("mrst0_rd_ready", rd_ready, 1'b1);
      cyc(0, 0, 0, 1, '0, 'h61);
      chkb("mrst1_rd_ready", rd_ready, 1'b1);
      cyc(1, 0, 0, 1, '0, 'h62);
      chkb("mrst2_rd_ready", rd_ready, 1'b0);
      chkb("mrst2_ram_en", ram_en, 1'b1);
      for (int k = 3; k < 9; k++) begin
         cyc(0, 0, 0, 0, '0, '0);
         chkb($sformatf("mrst%0d_rd_dv", k), rd_data_valid, 1'b0);
         chkb($sformatf("mrst%0d_idle", k), idle, 1'b1);
         chkb($sformatf("mrst%0d_ram_en", k), ram_en, 1'b0);
      end
      chkv("mrst_ram_addr", DW'(ram_addr), '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
